// File: rtl/lt24_hires_nios2_gen2_0_cpu_dbg_memctl.sv
// Purpose : Debug-monitor memory controller. It turns one-cycle JTAG command pulses into
//           single Avalon-MM word reads and writes at the monitor address register.
// Latency : The strobe rises 1 cycle after a command pulse. A zero-wait access completes
//           2 cycles after the pulse.
// Backpr. : dbg_waitrequest stalls the strobe for at most TIMEOUT cycles. After that the
//           access is abandoned and flagged as an error.
// Ports   : clk/reset_n; jdo + take_* command pulses and debugack from the JTAG side;
//           MonDReg/monitor_ready/monitor_error status back; dbg_* Avalon-MM master.
module lt24_hires_nios2_gen2_0_cpu_dbg_memctl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] dbg_address,
  output logic              dbg_read,
  output logic              dbg_write,
  output logic [31:0]       dbg_writedata,
  input  logic [31:0]       dbg_readdata,
  input  logic              dbg_waitrequest
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  // 10 bits covers the full TIMEOUT range of 1..1023.
  localparam int              CNT_W      = 10;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [31:0]         mon_d_q, mon_d_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                start_rd, start_wr, cmd_any;

  // jdo bits outside the address and data fields carry nothing for this block.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  always_comb begin
    state_d  = state_q;
    mon_a_d  = mon_a_q;
    mon_d_d  = mon_d_q;
    ready_d  = ready_q;
    error_d  = error_q;
    stall_d  = stall_q;
    start_rd = 1'b0;
    start_wr = 1'b0;
    cmd_any  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    unique case (state_q)
      IDLE: begin
        // A write pulse wins over an address load, and an address load wins over a bare
        // read. The losing pulses are simply dropped.
        if (take_action_ocimem_b) begin
          mon_d_d  = jdo[34:3];
          start_wr = 1'b1;
        end else if (take_action_ocimem_a) begin
          mon_a_d  = jdo[ADDR_W+25:26];
          if (jdo[24]) error_d = 1'b0;
          start_rd = jdo[25];
        end else if (take_no_action_ocimem_a) begin
          start_rd = 1'b1;
        end

        if (start_rd || start_wr) begin
          if (debugack) begin
            state_d = start_wr ? WR : RD;
            ready_d = 1'b0;
            stall_d = '0;
          end else begin
            // The CPU is not halted. Refuse the access, but report the command as done.
            error_d = 1'b1;
            ready_d = 1'b1;
          end
        end
      end

      RD, WR: begin
        if (cmd_any) error_d = 1'b1;
        if (!dbg_waitrequest) begin
          if (state_q == RD) mon_d_d = dbg_readdata;
          mon_a_d = mon_a_q + ADDR_W'(1);
          ready_d = 1'b1;
          state_d = IDLE;
          stall_d = '0;
        end else if (stall_q == STALL_LAST) begin
          // This is the TIMEOUT-th stalled cycle. Give up and leave both registers untouched.
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
          stall_d = '0;
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      ready_q <= ready_d;
      error_q <= error_d;
      stall_q <= stall_d;
    end
  end

  // The strobes decode directly from the state. They are mutually exclusive, and both drop
  // in the cycle after completion, timeout or reset.
  assign dbg_read      = (state_q == RD);
  assign dbg_write     = (state_q == WR);
  assign dbg_address   = mon_a_q;
  assign dbg_writedata = mon_d_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_lt24_hires_nios2_gen2_0_cpu_dbg_memctl.sv
module tb_lt24_hires_nios2_gen2_0_cpu_dbg_memctl;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [37:0]       jdo = '0;
  logic              act_a = 1'b0, act_b = 1'b0, noact_a = 1'b0;
  logic              debugack = 1'b0;
  logic [31:0]       mon_d;
  logic              mon_rdy, mon_err;
  logic [ADDR_W-1:0] dbg_address;
  logic              dbg_read, dbg_write;
  logic [31:0]       dbg_writedata;
  logic [31:0]       dbg_readdata = '0;
  logic              dbg_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;

  lt24_hires_nios2_gen2_0_cpu_dbg_memctl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (act_a),
    .take_action_ocimem_b   (act_b),
    .take_no_action_ocimem_a(noact_a),
    .debugack               (debugack),
    .MonDReg                (mon_d),
    .monitor_ready          (mon_rdy),
    .monitor_error          (mon_err),
    .dbg_address            (dbg_address),
    .dbg_read               (dbg_read),
    .dbg_write              (dbg_write),
    .dbg_writedata          (dbg_writedata),
    .dbg_readdata           (dbg_readdata),
    .dbg_waitrequest        (dbg_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference model: at most one access in flight, which ends on a
  // wait-free cycle or after TIMEOUT stalled cycles.
  bit        m_busy = 0, m_wr = 0, m_rdy = 0, m_err = 0;
  int        m_stalls = 0;
  int        m_addr = 0;
  bit [31:0] m_data = 0;

  task automatic m_start(input bit wr);
    if (debugack) begin
      m_busy = 1; m_wr = wr; m_stalls = 0; m_rdy = 0;
    end else begin
      m_err = 1; m_rdy = 1;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_wr = 0; m_rdy = 0; m_err = 0; m_stalls = 0; m_addr = 0; m_data = 0;
    end else if (!m_busy) begin
      if (act_b) begin
        m_data = jdo[34:3];
        m_start(1);
      end else if (act_a) begin
        m_addr = int'(jdo[33:26]);
        if (jdo[24]) m_err = 0;
        if (jdo[25]) m_start(0);
      end else if (noact_a) begin
        m_start(0);
      end
    end else begin
      if (act_a || act_b || noact_a) m_err = 1;
      if (!dbg_waitrequest) begin
        if (!m_wr) m_data = dbg_readdata;
        m_addr = (m_addr + 1) % (1 << ADDR_W);
        m_rdy  = 1;
        m_busy = 0;
      end else begin
        m_stalls++;
        if (m_stalls == TIMEOUT) begin
          m_busy = 0; m_err = 1; m_rdy = 1;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, well away from the sampling edge.
  always @(negedge clk) begin
    chk("read",      {31'd0, dbg_read},  {31'd0, m_busy && !m_wr});
    chk("write",     {31'd0, dbg_write}, {31'd0, m_busy && m_wr});
    chk("address",   {24'd0, dbg_address}, m_addr[31:0]);
    chk("mondreg",   mon_d, m_data);
    chk("writedata", dbg_writedata, m_data);
    chk("ready",     {31'd0, mon_rdy}, {31'd0, m_rdy});
    chk("error",     {31'd0, mon_err}, {31'd0, m_err});
    chk("exclusive", {31'd0, dbg_read && dbg_write}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    act_a = 0; act_b = 0; noact_a = 0;
  endtask

  int        cnt;
  bit [63:0] r64;
  int        stall_mode;

  initial begin
    #1 reset_n = 0;
    #1;
    chk("rst_mondreg", mon_d, 32'd0);
    chk("rst_ready",   {31'd0, mon_rdy}, 32'd0);
    chk("rst_strobe",  {30'd0, dbg_read, dbg_write}, 32'd0);
    tick(); tick();
    reset_n = 1;
    tick();

    // Address load with read, zero wait.
    debugack = 1; dbg_waitrequest = 0; dbg_readdata = 32'hDEADBEEF;
    jdo = '0; jdo[33:26] = 8'h10; jdo[25] = 1; act_a = 1;
    tick(); clear_pulses();
    chk("t1_read_hi", {31'd0, dbg_read}, 32'd1);
    chk("t1_addr",    {24'd0, dbg_address}, 32'h10);
    tick();
    chk("t1_read_lo", {31'd0, dbg_read}, 32'd0);
    chk("t1_data",    mon_d, 32'hDEADBEEF);
    chk("t1_ready",   {31'd0, mon_rdy}, 32'd1);
    chk("t1_addr_inc",{24'd0, dbg_address}, 32'h11);

    // Write with three wait cycles at 0xFF, then the address wraps.
    jdo = '0; jdo[33:26] = 8'hFF; act_a = 1;
    tick(); clear_pulses();
    jdo = '0; jdo[34:3] = 32'h12345678; act_b = 1; dbg_waitrequest = 1;
    tick(); clear_pulses();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (dbg_write) cnt++;
      tick();
    end
    dbg_waitrequest = 0;
    if (dbg_write) cnt++;
    chk("t2_wdata", dbg_writedata, 32'h12345678);
    tick();
    chk("t2_wr_cycles", cnt[31:0], 32'd4);
    chk("t2_wrap",  {24'd0, dbg_address}, 32'h00);
    chk("t2_err",   {31'd0, mon_err}, 32'd0);

    // Timeout: the slave never releases.
    dbg_waitrequest = 1; noact_a = 1;
    tick(); clear_pulses();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (dbg_read) cnt++;
      tick();
    end
    chk("t3_rd_cycles", cnt[31:0], 32'd4);
    chk("t3_err",   {31'd0, mon_err}, 32'd1);
    chk("t3_ready", {31'd0, mon_rdy}, 32'd1);
    chk("t3_addr",  {24'd0, dbg_address}, 32'h00);
    dbg_waitrequest = 0;

    // Refusal, then clear, then a command pulse while busy.
    jdo = '0; jdo[33:26] = 8'h20; jdo[24] = 1; act_a = 1;
    tick(); clear_pulses();
    debugack = 0; noact_a = 1;
    tick(); clear_pulses();
    chk("t4_refuse_rd", {31'd0, dbg_read}, 32'd0);
    chk("t4_refuse_err",{31'd0, mon_err}, 32'd1);
    jdo = '0; jdo[33:26] = 8'h20; jdo[24] = 1; act_a = 1;
    tick(); clear_pulses();
    chk("t4_cleared", {31'd0, mon_err}, 32'd0);
    debugack = 1; dbg_waitrequest = 1; noact_a = 1;
    tick(); noact_a = 1;
    tick(); clear_pulses();
    chk("t4_busy_err", {31'd0, mon_err}, 32'd1);
    chk("t4_still_rd", {31'd0, dbg_read}, 32'd1);
    dbg_waitrequest = 0; dbg_readdata = 32'hA5A55A5A;
    tick();
    chk("t4_data", mon_d, 32'hA5A55A5A);
    chk("t4_addr", {24'd0, dbg_address}, 32'h21);

    // Priority: the write wins over the simultaneous read.
    jdo = '0; jdo[33:26] = 8'h30; jdo[24] = 1; act_a = 1;
    tick(); clear_pulses();
    jdo = '0; jdo[34:3] = 32'h0BADF00D; act_b = 1; noact_a = 1;
    tick(); clear_pulses();
    chk("t5_wr_only", {30'd0, dbg_read, dbg_write}, 32'd1);
    tick();
    chk("t5_done",    {30'd0, dbg_read, dbg_write}, 32'd0);
    chk("t5_addr",    {24'd0, dbg_address}, 32'h31);

    // Reset during a stalled read.
    dbg_waitrequest = 1; dbg_readdata = 32'hCAFEF00D; noact_a = 1;
    tick(); clear_pulses();
    tick();
    reset_n = 0;
    #1;
    chk("t6_rst_out", {mon_d[0], mon_rdy, mon_err, dbg_read, dbg_write}, 32'd0);
    tick(); tick();
    dbg_waitrequest = 0;
    reset_n = 1;
    tick();
    chk("t6_no_update", mon_d, 32'd0);
    chk("t6_addr",      {24'd0, dbg_address}, 32'd0);

    // Randomized traffic against the model.
    stall_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      r64 = {$urandom(), $urandom()};
      jdo = r64[37:0];
      act_a   = ($urandom_range(0, 5) == 0);
      act_b   = ($urandom_range(0, 7) == 0);
      noact_a = ($urandom_range(0, 5) == 0);
      debugack = ($urandom_range(0, 7) != 0);
      dbg_readdata = $urandom();
      if ($urandom_range(0, 40) == 0) stall_mode = 1 - stall_mode;
      dbg_waitrequest = (stall_mode == 1) ? ($urandom_range(0, 9) != 0)
                                          : ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 600) == 0) reset_n = 0;
      else if (!reset_n && $urandom_range(0, 2) == 0) reset_n = 1;
      tick();
    end
    clear_pulses();
    reset_n = 1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/lt24_hires_nios2_gen2_0_cpu_dbg_memctl.md
LT24_HIRES_NIOS2_GEN2_0_CPU_DBG_MEMCTL -- requirements
Module: lt24_hires_nios2_gen2_0_cpu_dbg_memctl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the debug memory port.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waitrequest may stall an access (range 1..1023).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have these ports:
- jdo  in  38  sysclk-domain JTAG data.
- take_action_ocimem_a  in  1  one-cycle pulse: address load / optional read.
- take_action_ocimem_b  in  1  one-cycle pulse: write MonDReg data.
- take_no_action_ocimem_a  in  1  one-cycle pulse: read at current address.
- debugack  in  1  CPU is halted in debug mode.
- MonDReg  out  32  monitor data register.
- monitor_ready  out  1  last command completed.
- monitor_error  out  1  sticky error flag.
- dbg_address  out  ADDR_W  memory word address.
- dbg_read / dbg_write  out  1 each  Avalon-MM strobes.
- dbg_writedata  out  32  write data (equals MonDReg).
- dbg_readdata  in  32  read data, valid when dbg_read high and dbg_waitrequest low.
- dbg_waitrequest  in  1  slave stall.

Function
REQ-005 SHALL implement states IDLE, RD, WR; only IDLE accepts commands.
REQ-006 SHALL, on take_action_ocimem_a in IDLE: MonAReg <= jdo[ADDR_W+25:26]; if jdo[24]=1 clear monitor_error; if jdo[25]=1 start a read at the new address.
REQ-007 SHALL, on take_no_action_ocimem_a in IDLE, start a read at current MonAReg.
REQ-008 SHALL, on take_action_ocimem_b in IDLE, load MonDReg <= jdo[34:3] and start a write at current MonAReg.
REQ-009 SHALL priority-order simultaneous pulses: action_b > action_a > no_action_a; lower-priority pulses that cycle are dropped without error.
REQ-010 SHALL, on starting any access, clear monitor_ready and enter RD/WR next cycle with strobe asserted; dbg_address=MonAReg held stable.
REQ-011 SHALL refuse an access when debugack=0 at the command cycle: no strobe, monitor_error<=1, monitor_ready<=1, stay IDLE (address load of REQ-006 still applies).
REQ-012 SHALL hold strobe while dbg_waitrequest=1; completion is first cycle strobe high and waitrequest low.
REQ-013 SHALL at read completion capture MonDReg <= dbg_readdata; at any completion set monitor_ready<=1, MonAReg <= MonAReg+1 (wrap modulo 2^ADDR_W), return to IDLE, deassert strobe next cycle.
REQ-014 SHALL count stalled strobe cycles; when count reaches TIMEOUT with waitrequest still high, drop strobe, set monitor_error and monitor_ready, leave MonDReg and MonAReg unchanged, return to IDLE.
REQ-015 SHALL, for any command pulse in RD/WR, ignore it and set monitor_error<=1.
REQ-016 SHALL never assert dbg_read and dbg_write together; minimum latency command pulse to strobe = 1 cycle; zero-wait access completes 2 cycles after pulse.
REQ-017 SHALL keep monitor_error sticky until cleared per REQ-006 or reset.

Reset
REQ-018 SHALL on reset_n=0 asynchronously force: state IDLE, MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, dbg_read=0, dbg_write=0, stall counter=0.
REQ-019 SHALL, if reset asserts mid-access, abort the access immediately; no completion side effects after release.

Verification
REQ-020 Address load: debugack=1, action_a with jdo[33:26]=0x10, jdo[25]=1, slave returns 0xDEADBEEF no wait -> dbg_address=0x10 read 1 cycle, MonDReg=0xDEADBEEF, monitor_ready=1, MonAReg=0x11.
REQ-021 Write with 3 wait cycles: action_b jdo[34:3]=0x12345678 at MonAReg=0xFF -> dbg_write high 4 cycles, writedata 0x12345678, MonAReg wraps to 0x00, monitor_error=0.
REQ-022 Timeout: TIMEOUT=4, waitrequest held 1 -> strobe drops after 4 stalled cycles, monitor_error=1, monitor_ready=1, MonAReg unchanged.
REQ-023 Refusal and busy: debugack=0 read -> no strobe, error=1; then action_a jdo[24]=1 clears; no_action_a during RD -> error=1, access completes normally.
REQ-024 Priority and reset: action_b and no_action_a same cycle -> only write issued; reset_n low during RD stall -> all outputs 0, no MonDReg update after release.
